lfsr_rand_range: RTL and testbench

Parametrised Fibonacci LFSR with a programmable tap mask, a seed load and all-zero lock-up recovery. It also contains a request/valid front end that returns uniformly distributed values in [0, LIMIT) using rejection sampling. The LFSR free-runs every clock so that entropy accumulates between requests. It sits between game control and the food/spawn placement logic, which need grid coordinates that are guaranteed to be in range.

---
 rtl/lfsr_rand_range.sv | 116 +++++++++++
 tb/tb_lfsr_rand_range.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand_range.sv
// Free-running Fibonacci LFSR with seed load and zero lock-up recovery, plus a
// request/valid front end that returns values in [0, LIMIT) by rejection sampling.
module lfsr_rand_range #(
    parameter int               WIDTH     = 12,
    parameter logic [WIDTH-1:0] TAPS      = 12'h829,
    parameter logic [WIDTH-1:0] INIT      = WIDTH'(1),
    parameter int               OUT_W     = 10,
    parameter int               LIMIT     = 768,
    parameter int               MAX_TRIES = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Seed_Load,
    input  logic [WIDTH-1:0] i_Seed,
    input  logic             i_Req,
    output logic             o_Busy,
    output logic             o_Valid,
    output logic [OUT_W-1:0] o_Data,
    output logic             o_Fallback,
    output logic [WIDTH-1:0] o_State,
    output logic             o_Lockup
);

    localparam int               TRY_W     = $clog2(MAX_TRIES + 1);
    localparam logic [OUT_W:0]   LIMIT_EXT = (OUT_W + 1)'(LIMIT);
    localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);
    // Clearing the top bit always lands below LIMIT because LIMIT > 2^(OUT_W-1).
    localparam logic [OUT_W-1:0] LOW_MASK  = {1'b0, {(OUT_W - 1){1'b1}}};

    typedef enum logic {
        IDLE,
        SAMPLE
    } fsm_t;

    fsm_t             fsm;
    fsm_t             fsm_next;
    logic [WIDTH-1:0] state;
    logic [TRY_W-1:0] tries;
    logic [OUT_W-1:0] candidate;
    logic             feedback;
    logic             in_range;
    logic             give_up;
    logic             done;

    assign feedback  = ^(state & TAPS);
    assign candidate = state[OUT_W-1:0];
    assign in_range  = {1'b0, candidate} < LIMIT_EXT;
    assign o_State   = state;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= INIT;
            o_Lockup <= 1'b0;
        end else if (i_Seed_Load) begin
            if (i_Seed == '0) begin
                state    <= INIT;
                o_Lockup <= 1'b1;
            end else begin
                state    <= i_Seed;
                o_Lockup <= 1'b0;
            end
        end else if (state == '0) begin
            state    <= INIT;
            o_Lockup <= 1'b1;
        end else begin
            state    <= {state[WIDTH-2:0], feedback};
            o_Lockup <= 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (i_Req) fsm_next = SAMPLE;
            SAMPLE:  if (done)  fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_comb begin
        o_Busy  = (fsm == SAMPLE);
        give_up = (fsm == SAMPLE) && !in_range && (tries == LAST_TRY);
        done    = (fsm == SAMPLE) && (in_range || give_up);
    end

    // The candidate is the pre-advance state, so a seed load mid-sample only
    // affects the following attempt.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tries      <= '0;
            o_Valid    <= 1'b0;
            o_Data     <= '0;
            o_Fallback <= 1'b0;
        end else begin
            o_Valid <= done;
            if (fsm == IDLE) begin
                if (i_Req) tries <= '0;
            end else if (!in_range) begin
                tries <= tries + TRY_W'(1);
            end
            if (done) begin
                o_Data     <= in_range ? candidate : (candidate & LOW_MASK);
                o_Fallback <= !in_range;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Self-checking bench for lfsr_rand_range: fixed scenarios plus a randomized
// level-held request soak checked against an arithmetic reference model.
module tb_lfsr_rand_range;

    localparam int         LIMIT     = 768;
    localparam int         MAX_TRIES = 16;
    localparam logic [11:0] TAPS     = 12'h829;

    logic        clk = 1'b0;
    logic        rst, seed_load, req;
    logic [11:0] seed;

    logic        busy, valid, fallback, lockup;
    logic [9:0]  data;
    logic [11:0] state;
    logic        busy_m1, valid_m1, fallback_m1, lockup_m1;
    logic [9:0]  data_m1;
    logic [11:0] state_m1;
    logic        busy_z, valid_z, fallback_z, lockup_z;
    logic [9:0]  data_z;
    logic [11:0] state_z;

    int vec_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    lfsr_rand_range dut (
        .i_Clk(clk), .i_Rst(rst), .i_Seed_Load(seed_load), .i_Seed(seed), .i_Req(req),
        .o_Busy(busy), .o_Valid(valid), .o_Data(data), .o_Fallback(fallback),
        .o_State(state), .o_Lockup(lockup)
    );

    lfsr_rand_range #(.MAX_TRIES(1)) dut_m1 (
        .i_Clk(clk), .i_Rst(rst), .i_Seed_Load(seed_load), .i_Seed(seed), .i_Req(req),
        .o_Busy(busy_m1), .o_Valid(valid_m1), .o_Data(data_m1), .o_Fallback(fallback_m1),
        .o_State(state_m1), .o_Lockup(lockup_m1)
    );

    // An all-zero tap mask just shifts the seed out, reaching the zero state naturally.
    lfsr_rand_range #(.TAPS(12'h000)) dut_z (
        .i_Clk(clk), .i_Rst(rst), .i_Seed_Load(seed_load), .i_Seed(seed), .i_Req(req),
        .o_Busy(busy_z), .o_Valid(valid_z), .o_Data(data_z), .o_Fallback(fallback_z),
        .o_State(state_z), .o_Lockup(lockup_z)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] model_next(input logic [11:0] s, input logic [11:0] taps);
        int v;
        if (s == 12'd0) return 12'd1;
        v = (int'(s) * 2) % 4096 + ($countones(s & taps) % 2);
        return v[11:0];
    endfunction

    // Walks future LFSR states from the first candidate to find the returned value.
    task automatic predict(input logic [11:0] start, input int max_tries,
                           output logic [9:0] pdata, output logic pfb, output int plat);
        logic [11:0] s;
        int          cand;
        s     = start;
        pdata = '0;
        pfb   = 1'b0;
        plat  = 0;
        for (int t = 1; t <= max_tries; t++) begin
            cand = int'(s) % 1024;
            if (cand < LIMIT) begin
                pdata = cand[9:0];
                plat  = t;
                return;
            end
            if (t == max_tries) begin
                pdata = 10'(cand % 512);
                pfb   = 1'b1;
                plat  = t;
                return;
            end
            s = model_next(s, TAPS);
        end
    endtask

    initial begin
        logic [11:0] ms;
        logic [11:0] exp_tbl [4];
        logic [9:0]  pd, pd1;
        logic        pf, pf1;
        int          pl, pl1;
        int          first_ret, zero_seen, valid_seen;

        exp_tbl = '{12'h003, 12'h007, 12'h00F, 12'h01E};
        rst = 1'b1; seed_load = 1'b0; seed = '0; req = 1'b0;

        // Reset state and the free-running sequence
        step();
        ms = 12'd1;
        check_output("rst_state", state, 12'h001);
        check_output("rst_valid", valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_data", data, 0);
        check_output("rst_fallback", fallback, 0);
        check_output("rst_lockup", lockup, 0);
        rst = 1'b0;
        first_ret = 0;
        zero_seen = 0;
        for (int k = 1; k <= 4095; k++) begin
            step();
            ms = model_next(ms, TAPS);
            if (k <= 4) check_output("seq_state", state, exp_tbl[k-1]);
            if (k <= 5) begin
                check_output("seq_valid", valid, 0);
                check_output("seq_lockup", lockup, 0);
            end
            check_output("free_run", state, ms);
            if (state == 12'd0) zero_seen++;
            if (state == 12'd1 && first_ret == 0) first_ret = k;
            if (k == 11) check_output("zero_pre", state_z, 12'h800);
            if (k == 12) begin
                check_output("zero_state", state_z, 12'h000);
                check_output("zero_nolock", lockup_z, 0);
            end
            if (k == 13) begin
                check_output("zero_recover", state_z, 12'h001);
                check_output("zero_lockup", lockup_z, 1);
            end
            if (k == 14) check_output("zero_lock_end", lockup_z, 0);
        end
        check_output("period", first_ret, 4095);
        check_output("no_zero", zero_seen, 0);

        // Seed 0x3FF, single request: long rejection run and MAX_TRIES=1 fallback
        rst = 1'b1; step(); rst = 1'b0;
        seed_load = 1'b1; seed = 12'h3FF;
        step();
        ms = 12'h3FF;
        seed_load = 1'b0;
        check_output("seed_state", state, 12'h3FF);
        req = 1'b1;
        step();
        ms = model_next(ms, TAPS);
        req = 1'b0;
        check_output("e1_busy", busy, 1);
        check_output("e1_busy_m1", busy_m1, 1);
        check_output("e1_state", state, ms);
        predict(ms, MAX_TRIES, pd, pf, pl);
        predict(ms, 1, pd1, pf1, pl1);
        for (int e = 2; e <= 12; e++) begin
            step();
            ms = model_next(ms, TAPS);
            check_output("s3_busy", busy, (e - 1) < pl);
            check_output("s3_valid", valid, (e - 1) == pl);
            check_output("s3_busy_m1", busy_m1, 0);
            check_output("s3_valid_m1", valid_m1, e == 2);
            if (e == 2) begin
                check_output("m1_data", data_m1, 10'h1FF);
                check_output("m1_fallback", fallback_m1, 1);
                check_output("m1_model", data_m1, pd1);
            end
            if (e == 12) begin
                check_output("s3_data", data, 10'h2B4);
                check_output("s3_fallback", fallback, 0);
                check_output("s3_model", data, pd);
            end
        end
        step();
        check_output("s3_pulse", valid, 0);
        check_output("s3_hold", data, 10'h2B4);

        // Zero seed is replaced by INIT with a lock-up pulse
        seed_load = 1'b1; seed = 12'h000;
        step();
        seed_load = 1'b0;
        check_output("zseed_state", state, 12'h001);
        check_output("zseed_lockup", lockup, 1);
        step();
        check_output("zseed_lock_end", lockup, 0);
        check_output("zseed_next", state, 12'h003);

        // Reset in the middle of a sample
        rst = 1'b1; step(); rst = 1'b0;
        seed_load = 1'b1; seed = 12'h3FF; step(); seed_load = 1'b0;
        req = 1'b1; step(); req = 1'b0;
        for (int e = 2; e <= 4; e++) begin
            step();
            check_output("mid_busy", busy, 1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        ms = 12'd1;
        check_output("mid_valid", valid, 0);
        check_output("mid_data", data, 0);
        check_output("mid_busy_rst", busy, 0);
        check_output("mid_state", state, 12'h001);
        check_output("mid_fallback", fallback, 0);
        valid_seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            ms = model_next(ms, TAPS);
            if (valid) valid_seen++;
        end
        check_output("mid_no_valid", valid_seen, 0);

        // Level-held request soak from a random seed
        seed_load = 1'b1;
        seed = 12'($urandom_range(1, 4095));
        step();
        seed_load = 1'b0;
        ms = seed;
        check_output("soak_seed", state, ms);
        req = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            step();
            ms = model_next(ms, TAPS);
            check_output("soak_gap", valid, 0);
            check_output("soak_busy", busy, 1);
            predict(ms, MAX_TRIES, pd, pf, pl);
            for (int t = 1; t <= pl; t++) begin
                step();
                ms = model_next(ms, TAPS);
                check_output("soak_valid", valid, t == pl);
            end
            check_output("soak_data", data, pd);
            check_output("soak_fallback", fallback, pf);
            check_output("soak_range", data < LIMIT, 1);
        end
        req = 1'b0;
        step();
        check_output("soak_final_gap", valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
